// File: rtl/countdown_timer_bcd_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
// Imported by the interface, the BCD counter and the timer top level.
package timer_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 4;
   localparam int MAX_W      = BCD_W * MAX_DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int calc_div(int clk_hz, int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   function automatic logic [MAX_W-1:0] to_bcd(int value, int digits);
      logic [MAX_W-1:0] r_bcd;
      int               v;
      r_bcd = '0;
      v     = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) begin
            r_bcd[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
         end
      end
      return r_bcd;
   endfunction

   // Out-of-range nibbles saturate to 9 so a bad preset still counts sensibly.
   function automatic logic [MAX_W-1:0] clamp_bcd(logic [MAX_W-1:0] value);
      logic [MAX_W-1:0] r_out;
      r_out = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (value[i*BCD_W +: BCD_W] > 4'd9) r_out[i*BCD_W +: BCD_W] = 4'd9;
      end
      return r_out;
   endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Control/status bundle between the responder FSM (master) and the
// countdown timer (slave); display and buzzer drivers tap the status side.
interface countdown_timer_bcd_if
   import timer_pkg::*;
#(
   parameter int DIGITS = 2
);
   logic                      start;
   logic                      pause;
   logic                      clear;
   logic                      load_en;
   logic [BCD_W*DIGITS-1:0]   load_val;
   logic [BCD_W*DIGITS-1:0]   count;
   logic                      tick;
   logic                      running;
   logic                      warn;
   logic                      expired;
   logic                      buzzer;
   logic                      led_over;

   modport master (
      output start, pause, clear, load_en, load_val,
      input  count, tick, running, warn, expired, buzzer, led_over
   );

   modport slave (
      input  start, pause, clear, load_en, load_val,
      output count, tick, running, warn, expired, buzzer, led_over
   );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with synchronous load; saturates at zero.
// o_next exposes the value the register takes on the coming edge.
module bcd_down_counter
   import timer_pkg::*;
#(
   parameter int                      DIGITS    = 2,
   parameter logic [BCD_W*DIGITS-1:0] RESET_VAL = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_load,
   input  logic [BCD_W*DIGITS-1:0]   i_load_val,
   input  logic                      i_dec,
   output logic [BCD_W*DIGITS-1:0]   o_value,
   output logic [BCD_W*DIGITS-1:0]   o_next,
   output logic                      o_zero
);
   localparam int CW = BCD_W * DIGITS;

   logic [CW-1:0] r_value;
   logic [CW-1:0] w_dec_val;
   logic          w_borrow;

   // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
   always_comb begin
      w_dec_val = r_value;
      w_borrow  = 1'b1;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_borrow) begin
            if (r_value[d*BCD_W +: BCD_W] == 4'd0) begin
               w_dec_val[d*BCD_W +: BCD_W] = 4'd9;
            end else begin
               w_dec_val[d*BCD_W +: BCD_W] = r_value[d*BCD_W +: BCD_W] - 4'd1;
               w_borrow                    = 1'b0;
            end
         end
      end
   end

   assign o_zero  = (r_value == '0);
   assign o_next  = i_load              ? i_load_val :
                    (i_dec && !o_zero)  ? w_dec_val  : r_value;
   assign o_value = r_value;

   // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_value <= RESET_VAL;
      else          r_value <= o_next;
   end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Answer-window countdown timer: FSM, tick prescaler, alarm pulse timer and
// warn comparator around a BCD down counter. All outputs are registered.
module countdown_timer_bcd
   import timer_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int DIGITS      = 2,
   parameter int START_VAL   = 30,
   parameter int WARN_VAL    = 5,
   parameter int ALARM_TICKS = 1
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   countdown_timer_bcd_if.slave bus
);
   localparam int CW  = BCD_W * DIGITS;
   localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
   localparam int PW  = $clog2(DIV);
   localparam int AW  = $clog2(ALARM_TICKS + 1);

   localparam logic [CW-1:0] START_BCD  = CW'(to_bcd(START_VAL, DIGITS));
   localparam logic [CW-1:0] WARN_BCD   = CW'(to_bcd(WARN_VAL, DIGITS));
   localparam logic [CW-1:0] ONE_BCD    = CW'(1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [AW-1:0] ALARM_INIT = AW'(ALARM_TICKS);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_PAUSE = ST_PAUSE;
   localparam logic [1:0] S_DONE  = ST_DONE;

   logic [1:0]    r_state, w_state_nxt;
   logic [CW-1:0] r_preset, w_preset_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [AW-1:0] r_alarm, w_alarm_nxt;
   logic          r_buzzer, w_buzzer_nxt;
   logic          r_tick, w_tick_nxt;
   logic          r_running, r_warn, r_expired;

   logic          w_load, w_dec, w_wrap, w_zero;
   logic [CW-1:0] w_load_val, w_load_clamped, w_count, w_count_nxt;

   assign w_wrap         = (r_presc == PRESC_LAST);
   assign w_load_clamped = CW'(clamp_bcd(MAX_W'(bus.load_val)));

   always_comb begin
      w_state_nxt  = r_state;
      w_preset_nxt = r_preset;
      w_presc_nxt  = r_presc;
      w_alarm_nxt  = r_alarm;
      w_buzzer_nxt = r_buzzer;
      w_tick_nxt   = 1'b0;
      w_load       = 1'b0;
      w_load_val   = r_preset;
      w_dec        = 1'b0;

      if (bus.clear) begin
         w_state_nxt  = S_IDLE;
         w_load       = 1'b1;
         w_presc_nxt  = '0;
         w_alarm_nxt  = '0;
         w_buzzer_nxt = 1'b0;
      end else if (bus.start) begin
         w_load      = 1'b1;
         w_presc_nxt = '0;
         if (r_preset == '0) begin
            w_state_nxt  = S_DONE;
            w_alarm_nxt  = ALARM_INIT;
            w_buzzer_nxt = 1'b1;
         end else begin
            w_state_nxt  = S_RUN;
            w_alarm_nxt  = '0;
            w_buzzer_nxt = 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.load_en) begin
                  w_preset_nxt = w_load_clamped;
                  w_load       = 1'b1;
                  w_load_val   = w_load_clamped;
               end
            end
            S_RUN: begin
               // The edge that samples pause neither advances the prescaler nor ticks.
               if (bus.pause) begin
                  w_state_nxt = S_PAUSE;
               end else if (w_wrap) begin
                  w_presc_nxt = '0;
                  w_tick_nxt  = 1'b1;
                  w_dec       = !w_zero;
                  if (w_count == ONE_BCD) begin
                     w_state_nxt  = S_DONE;
                     w_alarm_nxt  = ALARM_INIT;
                     w_buzzer_nxt = 1'b1;
                  end
               end else begin
                  w_presc_nxt = r_presc + PW'(1);
               end
            end
            S_PAUSE: begin
               if (!bus.pause) w_state_nxt = S_RUN;
            end
            S_DONE: begin
               if (bus.load_en) w_preset_nxt = w_load_clamped;
               if (w_wrap) begin
                  w_presc_nxt = '0;
                  w_tick_nxt  = 1'b1;
                  if (r_buzzer) begin
                     w_alarm_nxt = r_alarm - AW'(1);
                     if (r_alarm == AW'(1)) w_buzzer_nxt = 1'b0;
                  end
               end else begin
                  w_presc_nxt = r_presc + PW'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   bcd_down_counter #(
      .DIGITS    (DIGITS),
      .RESET_VAL (START_BCD)
   ) u_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_value    (w_count),
      .o_next     (w_count_nxt),
      .o_zero     (w_zero)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_preset  <= START_BCD;
         r_presc   <= '0;
         r_alarm   <= '0;
         r_buzzer  <= 1'b0;
         r_tick    <= 1'b0;
         r_running <= 1'b0;
         r_warn    <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_preset  <= w_preset_nxt;
         r_presc   <= w_presc_nxt;
         r_alarm   <= w_alarm_nxt;
         r_buzzer  <= w_buzzer_nxt;
         r_tick    <= w_tick_nxt;
         r_running <= (w_state_nxt == S_RUN);
         r_expired <= (w_state_nxt == S_DONE);
         // BCD of equal width orders like the integer, so a plain compare works.
         r_warn    <= ((w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSE)) &&
                      (w_count_nxt != '0) && (w_count_nxt <= WARN_BCD);
      end
   end

   assign bus.count    = w_count;
   assign bus.tick     = r_tick;
   assign bus.running  = r_running;
   assign bus.warn     = r_warn;
   assign bus.expired  = r_expired;
   assign bus.buzzer   = r_buzzer;
   assign bus.led_over = r_buzzer;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Self-checking bench for countdown_timer_bcd: directed scenarios followed by
// random control traffic, all compared each cycle against an integer model.
module tb_countdown_timer_bcd;
   localparam int CLK_HZ      = 10;
   localparam int TICK_HZ     = 1;
   localparam int DIGITS      = 2;
   localparam int START_VAL   = 30;
   localparam int WARN_VAL    = 5;
   localparam int ALARM_TICKS = 2;
   localparam int DIV         = CLK_HZ / TICK_HZ;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   countdown_timer_bcd_if #(.DIGITS(DIGITS)) bus ();

   countdown_timer_bcd #(
      .CLK_HZ      (CLK_HZ),
      .TICK_HZ     (TICK_HZ),
      .DIGITS      (DIGITS),
      .START_VAL   (START_VAL),
      .WARN_VAL    (WARN_VAL),
      .ALARM_TICKS (ALARM_TICKS)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit pause_lvl;

   // Reference model: plain integers for count/preset, cycles-left for the alarm.
   typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_e;
   mode_e m_mode;
   int    m_preset, m_count, m_phase, m_alarm_left;
   bit    m_tick;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [7:0] int_to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int clamp_to_int(input logic [7:0] lv);
      int hi, lo;
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      return hi * 10 + lo;
   endfunction

   function automatic logic [31:0] model_vec();
      bit run, wrn, exp_d, buz;
      run   = (m_mode == M_RUN);
      wrn   = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (m_count > 0) && (m_count <= WARN_VAL);
      exp_d = (m_mode == M_DONE);
      buz   = (m_alarm_left > 0);
      return {18'd0, int_to_bcd(m_count), m_tick, run, wrn, exp_d, buz, buz};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {18'd0, bus.count, bus.tick, bus.running, bus.warn, bus.expired, bus.buzzer, bus.led_over};
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_preset = START_VAL; m_count = START_VAL;
      m_phase = 0; m_alarm_left = 0; m_tick = 0;
   endtask

   task automatic model_step(input bit st, input bit pa, input bit cl, input bit le, input logic [7:0] lv);
      m_tick = 0;
      if (cl) begin
         m_mode = M_IDLE; m_count = m_preset; m_phase = 0; m_alarm_left = 0;
      end else if (st) begin
         m_phase = 0; m_count = m_preset;
         if (m_preset == 0) begin
            m_mode = M_DONE; m_alarm_left = ALARM_TICKS * DIV;
         end else begin
            m_mode = M_RUN; m_alarm_left = 0;
         end
      end else begin
         case (m_mode)
            M_IDLE: if (le) begin m_preset = clamp_to_int(lv); m_count = m_preset; end
            M_RUN: begin
               if (pa) m_mode = M_PAUSE;
               else begin
                  m_phase++;
                  if (m_phase == DIV) begin
                     m_phase = 0; m_tick = 1; m_count--;
                     if (m_count == 0) begin m_mode = M_DONE; m_alarm_left = ALARM_TICKS * DIV; end
                  end
               end
            end
            M_PAUSE: if (!pa) m_mode = M_RUN;
            M_DONE: begin
               if (le) m_preset = clamp_to_int(lv);
               if (m_alarm_left > 0) m_alarm_left--;
               m_phase++;
               if (m_phase == DIV) begin m_phase = 0; m_tick = 1; end
            end
         endcase
      end
   endtask

   // Drives one clock of inputs at a falling edge and checks all outputs at the next one.
   task automatic cycle(input bit st, input bit pa, input bit cl, input bit le, input logic [7:0] lv);
      bus.start = st; bus.pause = pa; bus.clear = cl; bus.load_en = le; bus.load_val = lv;
      model_step(st, pa, cl, le, lv);
      @(negedge clk);
      cyc++;
      check("vec", dut_vec(), model_vec());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, pause_lvl, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wait_count(input logic [7:0] target, input int budget);
      int n;
      n = 0;
      while (bus.count !== target && n < budget) begin
         idle(1);
         n++;
      end
      check($sformatf("reach_%h", target), 32'(bus.count), 32'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      bit st, cl, le;
      logic [7:0] lv;
      bus.start = 0; bus.pause = 0; bus.clear = 0; bus.load_en = 0; bus.load_val = '0;
      pause_lvl = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_count", 32'(bus.count), 32'h30);
      check("rst_flags", 32'({bus.tick, bus.running, bus.warn, bus.expired, bus.buzzer, bus.led_over}), 32'h0);

      // Full countdown from 30 with borrow, zero at cycle 300, 20-cycle alarm.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("running_after_start", 32'(bus.running), 32'h1);
      n = 0;
      while (bus.count !== 8'h00 && n < 400) begin
         idle(1);
         n++;
         if (n == 9)   check("hold_30", 32'(bus.count), 32'h30);
         if (n == 10)  check("first_dec", 32'({bus.count, bus.tick}), 32'({8'h29, 1'b1}));
         if (n == 110) check("borrow_19", 32'(bus.count), 32'h19);
      end
      check("zero_cycle", 32'(n), 32'd300);
      check("expired_buzzer", 32'({bus.expired, bus.buzzer, bus.led_over}), 32'b111);
      n = 0;
      while (bus.buzzer && n < 100) begin
         idle(1);
         n++;
      end
      check("buzzer_len", 32'(n), 32'(ALARM_TICKS * DIV));

      // Pause mid-tick at count 17, prescaler 4.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(134);
      check("at_17", 32'(bus.count), 32'h17);
      for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check("paused_hold", 32'({bus.count, bus.running}), 32'({8'h17, 1'b0}));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("resumed", 32'(bus.running), 32'h1);
      n = 0;
      while (bus.count === 8'h17 && n < 50) begin
         idle(1);
         n++;
      end
      check("resume_gap", 32'(n), 32'd6);

      // Warn window.
      wait_count(8'h06, 200);
      check("warn_06", 32'(bus.warn), 32'h0);
      wait_count(8'h05, 20);
      check("warn_05", 32'(bus.warn), 32'h1);
      wait_count(8'h01, 60);
      check("warn_01", 32'(bus.warn), 32'h1);
      wait_count(8'h00, 20);
      check("warn_00", 32'({bus.warn, bus.expired}), 32'b01);

      // Clear from DONE, clamped load, count 99 -> 98.
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("clear_idle", 32'({bus.count, bus.running, bus.buzzer}), 32'({8'h30, 2'b00}));
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h9C);
      check("load_clamp", 32'(bus.count), 32'h99);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle(9);
      check("hold_99", 32'(bus.count), 32'h99);
      idle(1);
      check("dec_98", 32'(bus.count), 32'h98);

      // clear beats start; start with preset 00 alarms immediately.
      idle(5);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check("clear_wins", 32'({bus.count, bus.running}), 32'({8'h99, 1'b0}));
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("zero_preset_done", 32'({bus.count, bus.expired, bus.buzzer}), 32'({8'h00, 2'b11}));

      // Async reset mid-count at 12.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h15);
      check("done_load_keeps_0", 32'(bus.count), 32'h00);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      wait_count(8'h12, 60);
      idle(3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst", 32'({bus.count, bus.tick, bus.running, bus.warn, bus.expired, bus.buzzer, bus.led_over}),
            32'({8'h30, 6'b0}));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic.
      for (int i = 0; i < 12000; i++) begin
         st = ($urandom_range(0, 149) == 0);
         cl = ($urandom_range(0, 299) == 0);
         le = ($urandom_range(0, 39) == 0);
         if (pause_lvl) begin
            if ($urandom_range(0, 9) == 0) pause_lvl = 1'b0;
         end else if ($urandom_range(0, 24) == 0) begin
            pause_lvl = 1'b1;
         end
         if ($urandom_range(0, 1) == 1) lv = 8'($urandom_range(0, 9));
         else                           lv = 8'($urandom);
         cycle(st, pause_lvl, cl, le, lv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
